mem_stage_dmem: RTL and testbench
=================================

MEM_STAGE_DMEM -- requirements
Module: mem_stage_dmem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge); reset input 1 (asynchronous, active-low).
REQ-002 The block SHALL expose these control inputs from EX/MEM:
- mem_enable input 1: access request.
- mem_rw input 1: 1=store, 0=load.
- mem_size input 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- mem_se input 1: sign-extend loads.
- load_instr input 1: writeback selects memory data.
- rf_enable input 1: register-file write.
REQ-003 The block SHALL expose these data inputs:
- MEM_ALU input 32: result/address; bits [8:0] are the byte address.
- MEM_PA input 32: store data.
- MEM_rd input 5: destination register.
REQ-004 The block SHALL expose these outputs:
- mem_stall output 1: upstream hold request.
- WB_data output 32: writeback value.
- WB_rd output 5: destination register.
- WB_rf_enable output 1: register-file write enable.
- misalign_err output 1: sticky error flag.

Function
REQ-005 Storage SHALL be 512 bytes, big-endian: byte at address A is bits [31:24] of a word at A.
REQ-006 The FSM SHALL have two states, IDLE and ACCESS. IDLE goes to ACCESS when mem_enable=1; ACCESS always returns to IDLE after one cycle.
REQ-007 mem_stall SHALL be combinational and equal 1 only when the state is IDLE and mem_enable=1. Upstream holds all inputs stable while mem_stall=1.
REQ-008 The array SHALL be read or written only in the ACCESS cycle. A store writes 1, 2 or 4 bytes from MEM_PA[7:0], [15:0] or [31:0] at the clock edge ending ACCESS.
REQ-009 Load data SHALL be assembled from the addressed bytes:
- mem_se=1: sign-extend to 32 bits.
- mem_se=0: zero-extend to 32 bits.
REQ-010 The WB registers SHALL update at the edge ending ACCESS, or at any edge in IDLE with mem_enable=0:
- WB_data = load data if load_instr=1, otherwise MEM_ALU.
- WB_rd = MEM_rd.
- WB_rf_enable = rf_enable.
REQ-011 While mem_stall=1, the WB registers SHALL load WB_rf_enable=0 (bubble), so each instruction writes back exactly once.
- Non-memory instructions have 1-cycle latency.
- Memory instructions have 2-cycle latency.
REQ-012 An address is misaligned when either condition holds:
- halfword with bit0=1;
- word with bits[1:0]≠00.
REQ-013 An address whose access extends past byte 511 SHALL wrap modulo 512.
REQ-014 Back-to-back memory instructions SHALL each take 2 cycles. There is no overlap between consecutive accesses.

Reset
REQ-015 While reset=0, the block SHALL force:
- state IDLE;
- WB_data=0, WB_rd=0, WB_rf_enable=0;
- misalign_err=0.
REQ-016 mem_stall SHALL be 0 during reset.
REQ-017 Reset SHALL NOT clear the memory array.
REQ-018 A reset asserted in ACCESS SHALL abort the access: no array write, and no writeback.

Configuration
REQ-019 The block SHALL provide macro DMEM_MISALIGN_TRAP_EN with the following behaviour.
- Defined: a misaligned access performs no store, and its load returns 0.
  - misalign_err is set at the end of ACCESS and stays 1 until reset.
  - WB_rf_enable is 0 for that instruction.
- Undefined: the address low bits are forced to alignment (halfword clears bit0, word clears bits[1:0]).
  - The access proceeds normally.
  - misalign_err is tied to 0.

Verification
REQ-020 Word store then load: store 0x8000_12FF to addr 0x010; then load word, rd=5 → WB_data=0x8000_12FF, WB_rd=5 two cycles after the load is presented; mem_stall high exactly one cycle per access.
REQ-021 Byte and half extension: after REQ-020, load byte addr 0x010 with se=1 → 0xFFFF_FF80; se=0 → 0x0000_0080; load halfword addr 0x012 with se=1 → 0x0000_12FF.
REQ-022 ALU pass-through: mem_enable=0, MEM_ALU=0x1234, rf_enable=1, rd=3 → next edge WB_data=0x1234, WB_rf_enable=1, mem_stall never asserted.
REQ-023 Misaligned word: load word at addr 0x011.
- With DMEM_MISALIGN_TRAP_EN: misalign_err=1 and WB_rf_enable=0.
- Without: the data from 0x010 is returned and misalign_err=0.
REQ-024 Reset mid-access: assert reset=0 in the ACCESS cycle of a store of 0xDEAD_BEEF to 0x020 → later load from 0x020 returns the prior contents; all outputs read 0 during reset.

Source files
------------

// File: rtl/mem_stage_dmem.sv
// MEM stage with a 512-byte big-endian data memory; optional misalign trap via DMEM_MISALIGN_TRAP_EN.
// Latency: 1 cycle for non-memory ops, 2 cycles (IDLE + ACCESS) for loads/stores.
// Backpressure: mem_stall holds upstream for the IDLE cycle of each access; a WB bubble is issued then.
module mem_stage_dmem (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        mem_rw,
    input  logic [1:0]  mem_size,
    input  logic        mem_se,
    input  logic        load_instr,
    input  logic        rf_enable,
    input  logic [31:0] MEM_ALU,
    input  logic [31:0] MEM_PA,
    input  logic [4:0]  MEM_rd,
    output logic        mem_stall,
    output logic [31:0] WB_data,
    output logic [4:0]  WB_rd,
    output logic        WB_rf_enable,
    output logic        misalign_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  mem_arr [0:511];

    logic        is_half;
    logic        is_word;
    logic [8:0]  addr_base;
    logic [8:0]  a0;
    logic [8:0]  a1;
    logic [8:0]  a2;
    logic [8:0]  a3;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic        access_blocked;
    logic [31:0] ld_data;
    logic        wr_en;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (mem_enable) begin
                    state_nxt = ACCESS;
                    mem_stall = reset;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- address decode ----------------
    assign is_half = (mem_size == 2'b01);
    assign is_word = mem_size[1];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned     = (is_half & MEM_ALU[0]) | (is_word & (|MEM_ALU[1:0]));
    assign access_blocked = misaligned;

    always_comb begin
        addr_base = MEM_ALU[8:0];
    end
`else
    assign access_blocked = 1'b0;

    // Unaligned addresses are silently rounded down to the access size.
    always_comb begin
        addr_base = MEM_ALU[8:0];
        if (is_word) begin
            addr_base[1:0] = 2'b00;
        end else if (is_half) begin
            addr_base[0] = 1'b0;
        end
    end
`endif

    // 9-bit adds wrap naturally modulo 512
    assign a0 = addr_base;
    assign a1 = addr_base + 9'd1;
    assign a2 = addr_base + 9'd2;
    assign a3 = addr_base + 9'd3;

    assign b0 = mem_arr[a0];
    assign b1 = mem_arr[a1];
    assign b2 = mem_arr[a2];
    assign b3 = mem_arr[a3];

    // ---------------- load assembly ----------------
    always_comb begin
        ld_data = 32'd0;
        if (!access_blocked) begin
            case (mem_size)
                2'b00:   ld_data = {{24{mem_se & b0[7]}}, b0};
                2'b01:   ld_data = {{16{mem_se & b0[7]}}, b0, b1};
                default: ld_data = {b0, b1, b2, b3};
            endcase
        end
    end

    // ---------------- store path (array is never reset) ----------------
    assign wr_en = reset && (state == ACCESS) && mem_rw && !access_blocked;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (mem_size)
                2'b00: begin
                    mem_arr[a0] <= MEM_PA[7:0];
                end
                2'b01: begin
                    mem_arr[a0] <= MEM_PA[15:8];
                    mem_arr[a1] <= MEM_PA[7:0];
                end
                default: begin
                    mem_arr[a0] <= MEM_PA[31:24];
                    mem_arr[a1] <= MEM_PA[23:16];
                    mem_arr[a2] <= MEM_PA[15:8];
                    mem_arr[a3] <= MEM_PA[7:0];
                end
            endcase
        end
    end

    // ---------------- writeback registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WB_data      <= 32'd0;
            WB_rd        <= 5'd0;
            WB_rf_enable <= 1'b0;
        end else if (state == ACCESS) begin
            WB_data      <= load_instr ? ld_data : MEM_ALU;
            WB_rd        <= MEM_rd;
            WB_rf_enable <= rf_enable & ~access_blocked;
        end else if (!mem_enable) begin
            WB_data      <= MEM_ALU;
            WB_rd        <= MEM_rd;
            WB_rf_enable <= rf_enable;
        end else begin
            // first cycle of a memory op: bubble so the instruction writes back once
            WB_rf_enable <= 1'b0;
        end
    end

    // ---------------- sticky error ----------------
`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else if ((state == ACCESS) && misaligned) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed, table-driven bench for mem_stage_dmem; expectations adapt to DMEM_MISALIGN_TRAP_EN.
module tb_mem_stage_dmem;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_enable = 1'b0;
    logic        mem_rw = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_se = 1'b0;
    logic        load_instr = 1'b0;
    logic        rf_enable = 1'b0;
    logic [31:0] MEM_ALU = 32'd0;
    logic [31:0] MEM_PA = 32'd0;
    logic [4:0]  MEM_rd = 5'd0;
    logic        mem_stall;
    logic [31:0] WB_data;
    logic [4:0]  WB_rd;
    logic        WB_rf_enable;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic        rw;
        logic [1:0]  size;
        logic        se;
        logic        ld;
        logic        rfe;
        logic [31:0] alu;
        logic [31:0] pa;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_rfe;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    mem_stage_dmem dut (
        .clk          (clk),
        .reset        (reset),
        .mem_enable   (mem_enable),
        .mem_rw       (mem_rw),
        .mem_size     (mem_size),
        .mem_se       (mem_se),
        .load_instr   (load_instr),
        .rf_enable    (rf_enable),
        .MEM_ALU      (MEM_ALU),
        .MEM_PA       (MEM_PA),
        .MEM_rd       (MEM_rd),
        .mem_stall    (mem_stall),
        .WB_data      (WB_data),
        .WB_rd        (WB_rd),
        .WB_rf_enable (WB_rf_enable),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic rw, input logic [1:0] size,
                                input logic se, input logic ld, input logic rfe,
                                input logic [31:0] alu, input logic [31:0] pa, input logic [4:0] rd,
                                input logic [31:0] exp_data, input logic exp_rfe, input logic exp_err);
        vec_t v;
        v.en = en; v.rw = rw; v.size = size; v.se = se; v.ld = ld; v.rfe = rfe;
        v.alu = alu; v.pa = pa; v.rd = rd;
        v.exp_data = exp_data; v.exp_rfe = exp_rfe; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        mem_enable = v.en;
        mem_rw     = v.rw;
        mem_size   = v.size;
        mem_se     = v.se;
        load_instr = v.ld;
        rf_enable  = v.rfe;
        MEM_ALU    = v.alu;
        MEM_PA     = v.pa;
        MEM_rd     = v.rd;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("stall_idle[%0d]", idx), {31'd0, mem_stall}, {31'd0, v.en});
        if (v.en) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_access[%0d]", idx), {31'd0, mem_stall}, 32'd0);
            chk($sformatf("bubble[%0d]", idx), {31'd0, WB_rf_enable}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk($sformatf("wb_data[%0d]", idx), WB_data, v.exp_data);
        chk($sformatf("wb_rd[%0d]", idx), {27'd0, WB_rd}, {27'd0, v.rd});
        chk($sformatf("wb_rfe[%0d]", idx), {31'd0, WB_rf_enable}, {31'd0, v.exp_rfe});
        chk($sformatf("err[%0d]", idx), {31'd0, misalign_err}, {31'd0, v.exp_err});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  WB_data, 32'd0);
        chk({tag, "_rd"},    {27'd0, WB_rd}, 32'd0);
        chk({tag, "_rfe"},   {31'd0, WB_rf_enable}, 32'd0);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
        chk({tag, "_err"},   {31'd0, misalign_err}, 32'd0);
    endtask

    initial begin
        //      en rw sz se ld rfe alu            pa             rd   exp_data                     rfe           err
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 32'h0000_0020, 32'h1122_3344, 0,  32'h0000_0020,              0,            0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 32'h0000_0010, 32'h8000_12FF, 0,  32'h0000_0010,              0,            0));
        tbl.push_back(mk(1, 0, 2, 0, 1, 1, 32'h0000_0010, 32'h0,         5,  32'h8000_12FF,              1,            0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 32'h0000_0010, 32'h0,         6,  32'hFFFF_FF80,              1,            0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 32'h0000_0010, 32'h0,         7,  32'h0000_0080,              1,            0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, 32'h0000_0012, 32'h0,         8,  32'h0000_12FF,              1,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_1234, 32'h0,         3,  32'h0000_1234,              1,            0));
        tbl.push_back(mk(1, 0, 3, 0, 1, 1, 32'h0000_0010, 32'h0,         9,  32'h8000_12FF,              1,            0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0000_03FF, 32'hFFFF_FF5A, 0,  32'h0000_03FF,              0,            0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 32'h0000_01FF, 32'h0,         10, 32'h0000_005A,              1,            0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0000_01FE, 32'hFFFF_C3A5, 0,  32'h0000_01FE,              0,            0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, 32'h0000_01FE, 32'h0,         11, 32'hFFFF_C3A5,              1,            0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 32'h0000_01FE, 32'h0,         11, 32'h0000_C3A5,              1,            0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 32'h0000_01FF, 32'h0,         12, 32'hFFFF_FFA5,              1,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 32'h0,         31, 32'hCAFE_F00D,              0,            0));
        tbl.push_back(mk(1, 0, 2, 0, 1, 1, 32'h0000_0011, 32'h0,         12, TRAP ? 32'h0 : 32'h8000_12FF, !TRAP,      TRAP));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0000_0013, 32'h0000_BEEF, 0,  32'h0000_0013,              0,            TRAP));
        tbl.push_back(mk(1, 0, 2, 0, 1, 1, 32'h0000_0010, 32'h0,         13, TRAP ? 32'h8000_12FF : 32'h8000_BEEF, 1, TRAP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_0055, 32'h0,         1,  32'h0000_0055,              1,            TRAP));

        // reset at start with a pending memory request on the inputs
        drive(mk(1, 1, 2, 1, 1, 1, 32'h0000_1234, 32'hFFFF_FFFF, 7, 32'h0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
        reset = 1'b1;

        foreach (tbl[i]) run_op(tbl[i], i);

        // reset asserted during the ACCESS cycle of a store must abort it
        @(negedge clk);
        drive(mk(1, 1, 2, 0, 0, 1, 32'h0000_0020, 32'hDEAD_BEEF, 4, 32'h0, 0, 0));
        @(posedge clk);
        #1;
        chk("mid_in_access_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_rst_hold");
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
        reset = 1'b1;
        run_op(mk(1, 0, 2, 0, 1, 1, 32'h0000_0020, 32'h0, 14, 32'h1122_3344, 1, 0), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
